nand_2x1: RTL and testbench
===========================

Name: nand_2x1

Overview:
- Bitwise 2-input NAND primitive for the lab gate library.
- Provides a purely combinational output plus a registered copy for use in clocked datapaths.
- Includes small on-block observability: input-combination coverage flags and a saturating output-toggle counter.
- Default configuration is a single-bit NAND; WIDTH widens it bitwise.

Parameters:
- WIDTH, 1, bit width of a, b, out, out_q; bitwise operation per lane.
- CNT_W, 8, width of toggle_cnt.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out  output  WIDTH  combinational NAND: out = ~(a & b).
- out_q  output  WIDTH  registered NAND, one-cycle latency.
- cov  output  4  sticky coverage flags for lane 0; bit index = {a[0],b[0]}.
- toggle_cnt  output  CNT_W  count of clock edges on which out_q changed value.

Behaviour:
- Combinational path:
  - out[i] = NOT(a[i] AND b[i]) for every lane; no clock involvement.
  - Unaffected by rst.
  - Truth table per lane: 00->1, 01->1, 10->1, 11->0.
  - X/Z on an input propagates per standard Verilog operator semantics; no masking.
- Registered path:
  - Each rising clk edge: out_q <= ~(a & b), sampled from current inputs.
  - Latency exactly 1 cycle from input change to out_q update.
  - rst high at an edge: out_q <= all ones (the NAND of zeroed inputs); rst has priority over the data update.
- Coverage:
  - Each non-reset edge: cov[{a[0],b[0]}] <= 1; other bits hold.
  - Bits are sticky; they are cleared only by rst (cov <= 4'b0000).
  - cov == 4'b1111 means all four lane-0 combinations have been seen.
- Toggle counter:
  - Each non-reset edge where the new out_q value differs from the current out_q (any lane), toggle_cnt increments by 1.
  - Saturates at 2^CNT_W-1; no wrap.
  - rst sets toggle_cnt to 0.
  - The reset-induced transition of out_q is not counted.
- Reset mid-operation:
  - All registered outputs take their reset values on that edge.
  - Normal operation resumes on the first edge with rst low.
  - out continues to track inputs throughout.
- Simultaneous a and b change: treated as a single input vector; no glitch-free guarantee on out; out_q samples only the settled value at the edge.

Test Plan:
- Apply a=0,b=0 with rst low and hold each vector 100 ns, then step a/b = 0/0, 0/1, 1/0, 1/1 -> out = 1, 1, 1, 0 within the same timestep.
- Using the same 0/0, 0/1, 1/0, 1/1 sequence on consecutive clock edges after reset -> out_q = 1, 1, 1, 0, each one edge after input change; cov ends at 4'b1111.
- Assert rst for one edge after out_q=0 and cov=1111 -> out_q=1, cov=0000, toggle_cnt=0 on that edge; out still equals ~(a&b).
- Alternate a/b between 1/1 and 0/0 every edge for 300 edges -> toggle_cnt saturates at 255 and holds; no wrap.
- Hold a=1,b=1 for 10 edges after reset -> out_q=0 after the first edge, toggle_cnt=1, cov=1000.
- With WIDTH=4: a=4'b1100, b=4'b1010 -> out=4'b0111; out_q=4'b0111 one edge later.

Source files
------------

// File: rtl/nand_2x1.sv
// Bitwise 2-input NAND with a combinational output, a registered copy,
// sticky lane-0 input coverage flags and a saturating output-toggle counter.
module nand_2x1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [3:0]       cov,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] nand_d;
  logic             toggle;

  assign nand_d = ~(a & b);
  assign out    = nand_d;

  // A toggle is the registered value about to change on this edge.
  assign toggle = (nand_d != out_q);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '1;
      cov        <= 4'b0000;
      toggle_cnt <= '0;
    end else begin
      out_q              <= nand_d;
      cov[{a[0], b[0]}]  <= 1'b1;
      if (toggle && (toggle_cnt != CNT_MAX)) begin
        toggle_cnt <= toggle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nand_2x1.sv
// Self-checking bench for nand_2x1: directed test-plan scenarios plus
// randomized traffic, checked against a truth-table/arithmetic reference model.
module tb_nand_2x1;

  localparam int W4 = 4;
  localparam int CMAX = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          a1, b1;
  logic          out1, out_q1;
  logic [3:0]    cov1, cov4;
  logic [7:0]    cnt1, cnt4;
  logic [W4-1:0] a4, b4, out4, out_q4;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [0:0]    m_q1;
  logic [W4-1:0] m_q4;
  bit            m_seen1 [4];
  bit            m_seen4 [4];
  int            m_cnt1, m_cnt4;

  always #5 clk = ~clk;

  nand_2x1 #(.WIDTH(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a1), .b(b1),
    .out(out1), .out_q(out_q1), .cov(cov1), .toggle_cnt(cnt1)
  );

  nand_2x1 #(.WIDTH(W4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4),
    .out(out4), .out_q(out_q4), .cov(cov4), .toggle_cnt(cnt4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Truth table lookup: NAND is 0 only when both inputs are 1.
  function automatic logic [W4-1:0] ref_nand(input logic [W4-1:0] x, input logic [W4-1:0] y);
    logic [W4-1:0] r;
    for (int i = 0; i < W4; i++) r[i] = (x[i] == 1'b1 && y[i] == 1'b1) ? 1'b0 : 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] seen_vec(input bit s [4]);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = s[i];
    return v;
  endfunction

  task automatic check_regs(input string tag);
    check({tag, ".out_q1"}, 32'(out_q1), 32'(m_q1));
    check({tag, ".cov1"},   32'(cov1),   32'(seen_vec(m_seen1)));
    check({tag, ".cnt1"},   32'(cnt1),   32'(m_cnt1));
    check({tag, ".out_q4"}, 32'(out_q4), 32'(m_q4));
    check({tag, ".cov4"},   32'(cov4),   32'(seen_vec(m_seen4)));
    check({tag, ".cnt4"},   32'(cnt4),   32'(m_cnt4));
  endtask

  // Drive inputs away from the clock edge and check the combinational path.
  task automatic set_in(input logic x1, input logic y1, input logic [W4-1:0] x4, input logic [W4-1:0] y4);
    logic [W4-1:0] e1;
    a1 = x1; b1 = y1; a4 = x4; b4 = y4;
    #1;
    e1 = ref_nand({3'b0, x1}, {3'b0, y1});
    check("out1", 32'(out1), 32'(e1[0]));
    check("out4", 32'(out4), 32'(ref_nand(x4, y4)));
  endtask

  // One rising edge: advance the model, then compare registered outputs.
  task automatic cycle(input string tag);
    logic [W4-1:0] n1, n4;
    @(posedge clk);
    if (rst) begin
      m_q1 = 1'b1; m_q4 = '1; m_cnt1 = 0; m_cnt4 = 0;
      for (int i = 0; i < 4; i++) begin m_seen1[i] = 0; m_seen4[i] = 0; end
    end else begin
      n1 = ref_nand({3'b0, a1}, {3'b0, b1});
      n4 = ref_nand(a4, b4);
      if (n1[0] != m_q1) m_cnt1 = (m_cnt1 + 1 > CMAX) ? CMAX : m_cnt1 + 1;
      if (n4 != m_q4)    m_cnt4 = (m_cnt4 + 1 > CMAX) ? CMAX : m_cnt4 + 1;
      m_q1 = n1[0];
      m_q4 = n4;
      m_seen1[2*int'(a1) + int'(b1)] = 1;
      m_seen4[2*int'(a4[0]) + int'(b4[0])] = 1;
    end
    #1;
    check_regs(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle("rst");
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] v;
    rst = 1'b1;
    a1 = 0; b1 = 0; a4 = '0; b4 = '0;
    #2;
    cycle("rst0");
    cycle("rst1");
    check("reset_out_q1", 32'(out_q1), 32'h1);
    check("reset_cov1", 32'(cov1), 32'h0);
    check("reset_cnt1", 32'(cnt1), 32'h0);
    rst = 1'b0;

    // Combinational truth table, each vector held 100 ns
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      set_in(v[1], v[0], {4{v[1]}}, {4{v[0]}});
      check("tt_out", 32'(out1), (i == 3) ? 32'h0 : 32'h1);
      for (int k = 0; k < 10; k++) cycle("hold");
    end

    // Registered sequence after reset; cov fills in
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      set_in(v[1], v[0], {4{v[1]}}, {4{v[0]}});
      cycle("seq");
      check("seq_out_q1", 32'(out_q1), (i == 3) ? 32'h0 : 32'h1);
    end
    check("seq_cov_full", 32'(cov1), 32'hf);

    // Reset mid-operation with out_q=0 and cov=1111
    do_reset();
    check("midrst_out_q1", 32'(out_q1), 32'h1);
    check("midrst_cov1", 32'(cov1), 32'h0);
    check("midrst_cnt1", 32'(cnt1), 32'h0);
    check("midrst_out1", 32'(out1), 32'h0);

    // Hold 1/1 for 10 edges
    set_in(1'b1, 1'b1, 4'hf, 4'hf);
    for (int k = 0; k < 10; k++) cycle("hold11");
    check("hold11_out_q1", 32'(out_q1), 32'h0);
    check("hold11_cnt1", 32'(cnt1), 32'h1);
    check("hold11_cov1", 32'(cov1), 32'h8);

    // Saturation: alternate 1/1 and 0/0 for 300 edges
    do_reset();
    for (int k = 0; k < 300; k++) begin
      if (k % 2 == 0) set_in(1'b1, 1'b1, 4'hf, 4'hf);
      else            set_in(1'b0, 1'b0, 4'h0, 4'h0);
      cycle("sat");
    end
    check("sat_cnt1", 32'(cnt1), 32'd255);
    check("sat_cnt4", 32'(cnt4), 32'd255);

    // Wide lane check
    set_in(1'b0, 1'b1, 4'b1100, 4'b1010);
    check("wide_out4", 32'(out4), 32'h7);
    cycle("wide");
    check("wide_out_q4", 32'(out_q4), 32'h7);

    // Randomized traffic with occasional reset
    do_reset();
    for (int k = 0; k < 300; k++) begin
      rst = ($urandom_range(0, 19) == 0);
      set_in(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
      cycle("rand");
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
